// File: rtl/mem_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge_if
// Bundles the CPU request/response handshake and the Avalon-MM style memory
// bus used by mem_bus_bridge.
//
// Modports:
//   slave  - the bridge's view. The bridge is the slave of the CPU handshake.
//            It receives requests and bus read data, and drives responses,
//            stall and the bus command.
//   master - the environment's view (CPU plus memory slave). It drives
//            requests, waitrequest and read data, and observes everything
//            else.
//
// Signals:
//   req_valid/req_write/req_size/req_addr/req_wdata : CPU access request
//   req_ready                                       : bridge can accept
//   resp_valid/resp_rdata/resp_err                  : completion pulse + data
//   stall                                           : CPU must hold its state
//   avm_address/avm_read/avm_write/avm_byteenable/
//   avm_writedata                                   : bus command
//   avm_waitrequest/avm_readdata                    : bus slave response
// ---------------------------------------------------------------------------
interface mem_bus_bridge_if;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport slave (
      input  req_valid, req_write, req_size, req_addr, req_wdata,
      input  avm_waitrequest, avm_readdata,
      output req_ready, resp_valid, resp_rdata, resp_err, stall,
      output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
   );

   modport master (
      output req_valid, req_write, req_size, req_addr, req_wdata,
      output avm_waitrequest, avm_readdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, stall,
      input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
   );
endinterface

// File: rtl/mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge
// Converts single CPU load/store requests (byte, halfword, word; any byte
// address) into word-aligned memory bus commands with byte enables and
// lane-replicated write data. Load data is shifted back down and
// zero-extended. Misaligned or illegal-size accesses are rejected without
// touching the bus. A bus command stalled by waitrequest for TIMEOUT cycles
// is abandoned with an error response.
//
// Parameters:
//   TIMEOUT - maximum number of waitrequest cycles before an access aborts
//             (must be at least 1)
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous reset, active low
//   bus   - mem_bus_bridge_if.slave (CPU handshake plus memory bus)
// ---------------------------------------------------------------------------
module mem_bus_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   mem_bus_bridge_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    lane;
   logic [1:0]    size;
   logic          write;

   logic          misaligned;
   logic          illegal;
   logic [3:0]    be_next;
   logic [31:0]   wd_next;
   logic [31:0]   rd_shift;
   logic [31:0]   rd_masked;
   logic          timeout_hit;

   // Handshake outputs. stall is released in the RESP cycle because the
   // result is already on resp_rdata/resp_err then, so the CPU can take it and
   // move on. It is also forced low while reset is held.
   assign bus.req_ready = (state == IDLE);
   assign bus.stall     = reset & ((state == BUS) | (bus.req_valid & (state == IDLE)));

   // Request decode: alignment check, byte enables and lane-replicated store
   // data, all worked out from the live request so they can be registered at
   // acceptance.
   always_comb begin
      misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      illegal    = (bus.req_size == 2'b11);
      be_next    = 4'b0000;
      wd_next    = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be_next = 4'b0001 << bus.req_addr[1:0];
            wd_next = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            be_next = 4'b0011 << bus.req_addr[1:0];
            wd_next = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            be_next = 4'b1111;
            wd_next = bus.req_wdata;
         end
         default: begin
            be_next = 4'b0000;
            wd_next = bus.req_wdata;
         end
      endcase
   end

   // Load data return path: move the addressed lane down to bit 0 and drop
   // everything above the access size so the result is zero-extended.
   always_comb begin
      rd_shift  = bus.avm_readdata >> {lane, 3'b000};
      rd_masked = rd_shift;
      case (size)
         2'b00:   rd_masked = {24'h000000, rd_shift[7:0]};
         2'b01:   rd_masked = {16'h0000, rd_shift[15:0]};
         default: rd_masked = rd_shift;
      endcase
      timeout_hit = (wait_cnt == LAST_WAIT);
   end

   // Main controller. All bus and response outputs are registered here, so
   // the bus command stays stable for as long as the slave holds waitrequest.
   // The timeout check fires on the wait cycle that would bring the counter
   // to TIMEOUT, which leaves the command on the bus for exactly TIMEOUT
   // cycles. A completion in the same cycle takes priority over the timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         wait_cnt           <= '0;
         lane               <= 2'b00;
         size               <= 2'b00;
         write              <= 1'b0;
         bus.resp_valid     <= 1'b0;
         bus.resp_err       <= 1'b0;
         bus.resp_rdata     <= 32'h0;
         bus.avm_address    <= 32'h0;
         bus.avm_read       <= 1'b0;
         bus.avm_write      <= 1'b0;
         bus.avm_byteenable <= 4'b0000;
         bus.avm_writedata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               bus.resp_valid <= 1'b0;
               if (bus.req_valid) begin
                  lane  <= bus.req_addr[1:0];
                  size  <= bus.req_size;
                  write <= bus.req_write;
                  if (misaligned || illegal) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= 32'h0;
                  end else begin
                     state              <= BUS;
                     wait_cnt           <= '0;
                     bus.avm_address    <= {bus.req_addr[31:2], 2'b00};
                     bus.avm_read       <= ~bus.req_write;
                     bus.avm_write      <= bus.req_write;
                     bus.avm_byteenable <= be_next;
                     bus.avm_writedata  <= wd_next;
                  end
               end
            end
            BUS: begin
               if (!bus.avm_waitrequest) begin
                  state          <= RESP;
                  bus.avm_read   <= 1'b0;
                  bus.avm_write  <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  if (!write) begin
                     bus.resp_rdata <= rd_masked;
                  end
               end else if (timeout_hit) begin
                  state          <= RESP;
                  wait_cnt       <= wait_cnt + 1'b1;
                  bus.avm_read   <= 1'b0;
                  bus.avm_write  <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
                  bus.resp_rdata <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               bus.resp_valid <= 1'b0;
               state          <= IDLE;
            end
            default: begin
               bus.resp_valid <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule
